vga_controller: RTL
===================

# vga_controller

Generates 640x480@60 VGA timing for the display pipeline. Sits directly upstream of the frame decoder: it issues pixel fetch coordinates early enough to cover the decoder's SRAM latency, takes back the decoded 24-bit colour, and drives the aligned RGB, sync and blank pins. It also gives game logic a vertical-blank strobe, so car positions change only between frames.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- PIPE_LATENCY, 2, clocks from fetch coordinate to valid `i_decoded_color`

Ports:
- i_clk  in  1  pixel clock (25 MHz). One clock domain. All logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high
- o_VGA_H  out  sram_pkg::MAP_H_WIDTH  fetch column to the frame decoder
- o_VGA_V  out  sram_pkg::MAP_V_WIDTH  fetch row to the frame decoder
- i_decoded_color  in  24  {R,G,B} returned by the frame decoder
- o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  pixel colour
- o_VGA_HS  out  1  horizontal sync, active-low
- o_VGA_VS  out  1  vertical sync, active-low
- o_VGA_BLANK_N  out  1  high during visible pixels
- o_VGA_SYNC_N  out  1  tied 0
- o_vblank_start  out  1  one-clock pulse at the start of vertical blank
- o_in_vblank  out  1  high while the fetch row is at or beyond V_ACTIVE
- i_test_mode  in  1  selects the test pattern; present only with VGA_TEST_PATTERN_EN

## Operation
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800. It wraps to 0 and advances v_cnt.
- v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525. It wraps to 0.
- Both counters are 10 bits, unsigned.
- Horizontal phase FSM, decoded from h_cnt:
  - H_ACT: 0..639
  - H_FP: 640..655
  - H_SY: 656..751
  - H_BP: 752..799
  - H_BP returns to H_ACT.
- Vertical phases follow the same pattern on v_cnt: V_ACT, V_FP, V_SY, V_BP.
- Fetch coordinates:
  - In H_ACT and V_ACT, o_VGA_H = h_cnt and o_VGA_V = v_cnt.
  - Otherwise both are 0. This keeps the decoder within map bounds.
  - They are taken straight from the counter registers.
- Raw controls per clock:
  - hs_raw = 0 in H_SY.
  - vs_raw = 0 in V_SY.
  - de_raw = 1 in H_ACT and V_ACT.
- hs_raw, vs_raw and de_raw pass through a delay line of PIPE_LATENCY stages. They then go through one output register alongside i_decoded_color.
- Output register:
  - RGB = i_decoded_color when the delayed de is 1, otherwise 0.
  - o_VGA_BLANK_N = delayed de.
- o_vblank_start pulses when h_cnt = 0 and v_cnt = V_ACTIVE. It is in counter time, not delayed.
- o_in_vblank = (v_cnt >= V_ACTIVE).

## Timing
- Reset values:
  - Counters 0 and all delay stages in the inactive state (hs = 1, vs = 1, de = 0).
  - o_VGA_H = 0, o_VGA_V = 0.
  - RGB = 0, o_VGA_HS = 1, o_VGA_VS = 1, o_VGA_BLANK_N = 0.
  - o_vblank_start = 0, o_in_vblank = 0.
- Latency: coordinate (h,v) issued at clock t appears on RGB at t+PIPE_LATENCY+1. HS, VS and BLANK_N carry the same offset, so pixel and control stay aligned.
- First clock after i_rst falls issues (0,0). The first visible pixel appears PIPE_LATENCY+1 clocks later.
- Reset asserted mid-frame: on the next edge all counters and delay stages clear. Outputs show reset values, with no partial sync pulse stretched.
- Line wrap and frame wrap at (799,524) happen on the same edge: both counters go to 0.
- o_vblank_start fires exactly once per frame, 800×480 = 384000 clocks after frame start. Frame period is 420000 clocks.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - i_test_mode exists.
  - When i_test_mode = 1, the output register loads 8 vertical colour bars instead of i_decoded_color.
  - Each bar is 80 pixels wide. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - The bar is selected by the delayed h column.
  - Blanking still forces 0.
- VGA_TEST_PATTERN_EN undefined: the port and the mux are absent, and RGB always comes from i_decoded_color.

## Structure
- Add a vga_pkg containing:
  - the timing constants and derived H_TOTAL / V_TOTAL
  - the HPhase / VPhase enums
  - a typedef for the packed control tuple {hs, vs, de}
- Coordinate widths come from sram_pkg.
- One sub-module: VgaDelayLine, a parameterised N-stage shift register with synchronous reset value. It is used for the control tuple and, with the test pattern enabled, for the column.

## Test plan
- Reset then run 420000 clocks:
  - o_VGA_HS low for 96 clocks per 800.
  - o_VGA_VS low for 2 lines (1600 clocks).
  - 307200 clocks with BLANK_N = 1.
- Drive i_decoded_color = {o_VGA_V[7:0], o_VGA_H[7:0], 8'hA5}, delayed PIPE_LATENCY clocks. RGB must be (0, 0, A5) at the first visible pixel, and (0x12, 0x34, 0xA5) for fetch coordinate (0x34, 0x12).
- Check o_vblank_start pulses once at clock 384000 after reset release. o_in_vblank must be high for 36000 clocks per frame.
- Assert i_rst at h = 700, v = 490 (during VS):
  - next edge: HS = 1, VS = 1, BLANK_N = 0, o_VGA_H = o_VGA_V = 0.
  - after release, the frame restarts at (0,0).
- With VGA_TEST_PATTERN_EN and i_test_mode = 1:
  - pixel 0 = FFFFFF
  - pixel 80 = FFFF00
  - pixel 560 = 000000
  - blanking regions stay 0.
- Check the boundary: fetch at h = 639 is nonzero, and at h = 640 the fetch coordinates return to 0.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: map coordinate widths shared by the frame decoder and the VGA
// timing generator.
package sram_pkg;

    localparam int MAP_H_WIDTH = 10;
    localparam int MAP_V_WIDTH = 9;

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, phase enums and the packed
// {hs, vs, de} control tuple carried down the output pipeline.
package vga_pkg;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FRONT      = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BACK       = 48;
    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FRONT      = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BACK       = 33;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_PIPE_LATENCY = 2;

    // Both raster counters are 10-bit unsigned.
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} HPhase;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} VPhase;

    // Syncs are active-low, so the idle tuple is hs = 1, vs = 1, de = 0.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/vga_controller_delay_line.sv
// VgaDelayLine: N-stage shift register that clears every stage to RST_VAL on
// synchronous reset. Used to align raster-time signals with decoded colour.
module VgaDelayLine #(
    parameter int             W       = 1,
    parameter int             N       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [N];

    // Shift one stage per clock; reset clears every stage, not just the head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_controller.sv
// vga_controller: VGA raster timing, fetch coordinates for the frame decoder,
// and the aligned RGB/sync/blank output register.
// Optional feature macro: VGA_TEST_PATTERN_EN adds i_test_mode and an
// 8-bar colour test pattern selectable in place of the decoded colour.
module vga_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FRONT      = VGA_H_FRONT,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BACK       = VGA_H_BACK,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FRONT      = VGA_V_FRONT,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BACK       = VGA_V_BACK,
    parameter int PIPE_LATENCY = VGA_PIPE_LATENCY
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                             i_test_mode,
`endif
    output logic [sram_pkg::MAP_H_WIDTH-1:0] o_VGA_H,
    output logic [sram_pkg::MAP_V_WIDTH-1:0] o_VGA_V,
    input  logic [23:0]                      i_decoded_color,
    output logic [7:0]                       o_VGA_R,
    output logic [7:0]                       o_VGA_G,
    output logic [7:0]                       o_VGA_B,
    output logic                             o_VGA_HS,
    output logic                             o_VGA_VS,
    output logic                             o_VGA_BLANK_N,
    output logic                             o_VGA_SYNC_N,
    output logic                             o_vblank_start,
    output logic                             o_in_vblank
);

    localparam int FH_W    = sram_pkg::MAP_H_WIDTH;
    localparam int FV_W    = sram_pkg::MAP_V_WIDTH;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_FP_BEG = cnt_t'(H_ACTIVE);
    localparam cnt_t H_SY_BEG = cnt_t'(H_ACTIVE + H_FRONT);
    localparam cnt_t H_BP_BEG = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_FP_BEG = cnt_t'(V_ACTIVE);
    localparam cnt_t V_SY_BEG = cnt_t'(V_ACTIVE + V_FRONT);
    localparam cnt_t V_BP_BEG = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);

    function automatic HPhase h_phase_of(input cnt_t c);
        if (c < H_FP_BEG)      return H_ACT;
        else if (c < H_SY_BEG) return H_FP;
        else if (c < H_BP_BEG) return H_SY;
        else                   return H_BP;
    endfunction

    function automatic VPhase v_phase_of(input cnt_t c);
        if (c < V_FP_BEG)      return V_ACT;
        else if (c < V_SY_BEG) return V_FP;
        else if (c < V_BP_BEG) return V_SY;
        else                   return V_BP;
    endfunction

    cnt_t  h_cnt_q, h_cnt_d;
    cnt_t  v_cnt_q, v_cnt_d;
    HPhase h_ph_q;
    VPhase v_ph_q;

    // Next raster position: line wrap advances the row, frame wrap clears both.
    always_comb begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? cnt_t'(0) : v_cnt_q + cnt_t'(1);
        end
    end

    // Raster counters plus the phase FSMs; phases are registered from the
    // next count so they always describe the current counter value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            h_ph_q  <= H_ACT;
            v_ph_q  <= V_ACT;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            h_ph_q  <= h_phase_of(h_cnt_d);
            v_ph_q  <= v_phase_of(v_cnt_d);
        end
    end

    logic fetch_act;
    assign fetch_act = (h_ph_q == H_ACT) && (v_ph_q == V_ACT);

    // Outside the visible area the decoder is pointed at (0,0) so it never
    // addresses beyond the map.
    assign o_VGA_H = fetch_act ? FH_W'(h_cnt_q) : '0;
    assign o_VGA_V = fetch_act ? FV_W'(v_cnt_q) : '0;

    // Game-logic strobes live in counter time, ahead of the pixel pipeline.
    assign o_vblank_start = (h_cnt_q == '0) && (v_cnt_q == V_FP_BEG);
    assign o_in_vblank    = (v_cnt_q >= V_FP_BEG);

    ctrl_t ctrl_raw, ctrl_dly;
    assign ctrl_raw.hs = (h_ph_q != H_SY);
    assign ctrl_raw.vs = (v_ph_q != V_SY);
    assign ctrl_raw.de = fetch_act;

    VgaDelayLine #(
        .W       ($bits(ctrl_t)),
        .N       (PIPE_LATENCY),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (ctrl_raw),
        .q_o   (ctrl_dly)
    );

    logic [23:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [23:0] bar_color(input logic [FH_W-1:0] col);
        logic [2:0] idx;
        idx = 3'(int'(col) / BAR_W);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [FH_W-1:0] col_dly;

    // The column follows the same latency as the decoder so bars line up with
    // the delayed blanking.
    VgaDelayLine #(
        .W       (FH_W),
        .N       (PIPE_LATENCY),
        .RST_VAL ('0)
    ) u_col_dly (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (o_VGA_H),
        .q_o   (col_dly)
    );

    // Test pattern replaces decoder colour when selected.
    always_comb begin
        pix_src = i_decoded_color;
        if (i_test_mode) begin
            pix_src = bar_color(col_dly);
        end
    end
`else
    assign pix_src = i_decoded_color;
`endif

    logic [23:0] rgb_q;
    logic        hs_q, vs_q, blank_n_q;

    // Output register: colour and delayed controls leave together, with
    // blanking forcing black.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= ctrl_dly.de ? pix_src : 24'h0;
            hs_q      <= ctrl_dly.hs;
            vs_q      <= ctrl_dly.vs;
            blank_n_q <= ctrl_dly.de;
        end
    end

    assign o_VGA_R       = rgb_q[23:16];
    assign o_VGA_G       = rgb_q[15:8];
    assign o_VGA_B       = rgb_q[7:0];
    assign o_VGA_HS      = hs_q;
    assign o_VGA_VS      = vs_q;
    assign o_VGA_BLANK_N = blank_n_q;
    assign o_VGA_SYNC_N  = 1'b0;

endmodule
